// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// One access in flight at a time: IDLE -> ACCESS (-> RESP for reads) -> IDLE.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mem_en_q, mem_en_d, mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                pick;

  // Next-state and registered-output logic; last_gnt_q names the owner of the in-flight access.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pick        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next.
          pick        = (req0 && req1) ? ~last_gnt_q : req1;
          state_d     = ACCESS;
          last_gnt_d  = pick;
          gnt0_d      = ~pick;
          gnt1_d      = pick;
          mem_en_d    = 1'b1;
          mem_wen_d   = pick ? we1 : we0;
          mem_addr_d  = pick ? addr1 : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = mem_wen_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (last_gnt_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = mem_rdata;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requester drivers, a sync RAM model,
// and a transaction-level reference that predicts grants and read returns.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_en, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                gap;
  } txn_t;

  typedef struct {
    int                cyc;
    logic              who;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } gexp_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rexp_t;

  int errors = 0;
  int checks = 0;

  txn_t  txq0[$], txq1[$];
  gexp_t gq[$];
  rexp_t rq0[$], rq1[$];
  int    glog[$];

  logic              d_req[2], d_we[2];
  logic [ADDR_W-1:0] d_addr[2];
  logic [DATA_W-1:0] d_wdata[2];
  logic              active[2];
  logic              gnt_seen[2];
  int                gap_cnt[2];

  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] tb_mem  [256];
  int                m_wait;

  assign req0 = d_req[0];   assign req1 = d_req[1];
  assign we0 = d_we[0];     assign we1 = d_we[1];
  assign addr0 = d_addr[0]; assign addr1 = d_addr[1];
  assign wdata0 = d_wdata[0]; assign wdata1 = d_wdata[1];

  function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
    return {a, ~a, 8'h3C, a ^ 8'h96};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(int n, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
    if (n == 0) txq0.push_back(t);
    else txq1.push_back(t);
  endtask

  // Synchronous single-port RAM: read data appears the cycle after en=1, wen=0.
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = init_val(ADDR_W'(i));
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_wen) tb_mem[mem_addr] <= mem_wdata;
        else mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  // Requester drivers: hold each request until its grant, then move on after the gap.
  initial begin
    txn_t t;
    for (int n = 0; n < 2; n++) begin
      d_req[n] = 1'b0; d_we[n] = 1'b0; d_addr[n] = '0; d_wdata[n] = '0;
      active[n] = 1'b0; gnt_seen[n] = 1'b0; gap_cnt[n] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (!rst_n) begin
          active[n] = 1'b0;
          gnt_seen[n] = 1'b0;
          d_req[n] = 1'b0;
        end else begin
          if (active[n] && gnt_seen[n]) begin
            active[n] = 1'b0;
            gnt_seen[n] = 1'b0;
            d_req[n] = 1'b0;
          end
          if (!active[n]) begin
            if (gap_cnt[n] > 0) gap_cnt[n]--;
            else if ((n == 0 && txq0.size() > 0) || (n == 1 && txq1.size() > 0)) begin
              t = (n == 0) ? txq0.pop_front() : txq1.pop_front();
              d_req[n] = 1'b1; d_we[n] = t.we; d_addr[n] = t.addr; d_wdata[n] = t.wdata;
              active[n] = 1'b1;
              gap_cnt[n] = t.gap;
            end
          end
        end
      end
    end
  end

  // Monitor (compare against scoreboard) followed by the reference model (predict).
  initial begin
    int                cyc;
    int                busy_end;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] exp_rdata[2];
    logic              m_last;
    logic              exp_g, exp_rv, who;
    gexp_t             g, ng;
    rexp_t             r, nr;
    cyc = 0; busy_end = 0; last_addr = '0; m_last = 1'b1; m_wait = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    g = '{0, 1'b0, 1'b0, '0, '0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(ADDR_W'(i));
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        gq.delete(); rq0.delete(); rq1.delete();
        m_wait = 0; m_last = 1'b1; busy_end = cyc; last_addr = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
      end else begin
        exp_g = (gq.size() > 0) && (gq[0].cyc == cyc);
        if (exp_g) begin
          g = gq.pop_front();
          last_addr = g.addr;
          busy_end = cyc + (g.we ? 0 : 1);
          chk("mem_wen", 32'(mem_wen), 32'(g.we));
          if (g.we) chk("mem_wdata", mem_wdata, g.wdata);
        end else begin
          chk("mem_wen_idle", 32'(mem_wen), 32'(0));
        end
        chk("gnt0", 32'(gnt0), 32'(exp_g && !g.who));
        chk("gnt1", 32'(gnt1), 32'(exp_g && g.who));
        chk("mem_en", 32'(mem_en), 32'(exp_g));
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        chk("busy", 32'(busy), 32'(cyc <= busy_end));
        if (gnt0) begin gnt_seen[0] = 1'b1; glog.push_back(0); end
        if (gnt1) begin gnt_seen[1] = 1'b1; glog.push_back(1); end

        exp_rv = (rq0.size() > 0) && (rq0[0].cyc == cyc);
        if (exp_rv) begin r = rq0.pop_front(); exp_rdata[0] = r.data; end
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv));
        chk("rdata0", rdata0, exp_rdata[0]);
        exp_rv = (rq1.size() > 0) && (rq1[0].cyc == cyc);
        if (exp_rv) begin r = rq1.pop_front(); exp_rdata[1] = r.data; end
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv));
        chk("rdata1", rdata1, exp_rdata[1]);

        // Reference: a free arbiter takes one request; write busy 1 cycle, read 2 plus return.
        if (m_wait == 0) begin
          if (req0 || req1) begin
            who = (req0 && req1) ? !m_last : req1;
            ng.cyc = cyc + 1; ng.who = who;
            ng.we = who ? we1 : we0;
            ng.addr = who ? addr1 : addr0;
            ng.wdata = who ? wdata1 : wdata0;
            gq.push_back(ng);
            if (ng.we) begin
              ref_mem[ng.addr] = ng.wdata;
              m_wait = 1;
            end else begin
              nr.cyc = cyc + 3; nr.data = ref_mem[ng.addr];
              if (who) rq1.push_back(nr); else rq0.push_back(nr);
              m_wait = 2;
            end
            m_last = who;
          end
        end else begin
          m_wait--;
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_gnt0", 32'(gnt0), 0);       chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0); chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata0", rdata0, 0);        chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_en", 32'(mem_en), 0);   chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);  chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_drain(string name, int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (txq0.size() == 0) && (txq1.size() == 0) && !active[0] && !active[1] &&
           !d_req[0] && !d_req[1] && (gq.size() == 0) && (rq0.size() == 0) &&
           (rq1.size() == 0) && (m_wait == 0);
    end
    chk(name, 32'(ok), 1);
  endtask

  initial begin
    bit found;
    int n;
    do_reset();

    // Write then read back from requester 0.
    push_txn(0, 1'b1, 8'h05, 32'hDEADBEEF, 0);
    push_txn(0, 1'b0, 8'h05, 32'h0, 0);
    wait_drain("drain_wr_rd", 50);
    chk("rdata0_deadbeef", rdata0, 32'hDEADBEEF);
    chk("rdata1_untouched", rdata1, 32'h0);

    // Sustained dual reads from reset must alternate 0,1,0,1.
    do_reset();
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      push_txn(0, 1'b0, 8'(8'h20 + k), 32'h0, 0);
      push_txn(1, 1'b0, 8'(8'h40 + k), 32'h0, 0);
    end
    wait_drain("drain_rr", 100);
    chk("rr_count", 32'(glog.size()), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_order", 32'(glog[k]), 32'(k % 2));

    // Top address write/read by requester 1; address 0 untouched.
    push_txn(1, 1'b1, 8'hFF, 32'h12345678, 0);
    push_txn(1, 1'b0, 8'hFF, 32'h0, 0);
    push_txn(0, 1'b0, 8'h00, 32'h0, 2);
    wait_drain("drain_top", 100);
    chk("rdata1_top", rdata1, 32'h12345678);
    chk("rdata0_addr0", rdata0, init_val(8'h00));

    // Reset in the middle of a read access.
    push_txn(0, 1'b0, 8'h10, 32'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt0) found = 1'b1;
    end
    chk("gnt0_before_reset", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    push_txn(0, 1'b0, 8'h11, 32'h0, 0);
    push_txn(1, 1'b0, 8'h12, 32'h0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    glog.delete();
    wait_drain("drain_after_reset", 100);
    chk("tie_after_reset", 32'(glog.size() > 0 ? glog[0] : 9), 0);

    // Randomised traffic, mostly on a small address window to hit read-after-write.
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(0, 1));
      push_txn(n, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
               $urandom, int'($urandom_range(0, 3)));
    end
    wait_drain("drain_random", 5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
